// File: rtl/vic_cache_wb.sv
// Fully-associative victim cache sitting between L1 and the memory bus.
// Slot 0 holds the newest line and slot NUM_ENTRIES-1 the oldest. A lookup hit
// hands the line back to L1 and removes it. Dirty lines that overflow, and
// dirty lines drained by a flush, leave through a one-entry writeback buffer.
`ifndef NUM_TAG_BITS
`define NUM_TAG_BITS 20
`endif
`ifndef NUM_SET_BITS
`define NUM_SET_BITS 6
`endif

module vic_cache_wb #(
  parameter int NUM_ENTRIES = 4,
  parameter int TAG_BITS    = `NUM_TAG_BITS,
  parameter int SET_BITS    = `NUM_SET_BITS,
  parameter int DATA_BITS   = 64,
  localparam int OCC_W      = $clog2(NUM_ENTRIES + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 ins_valid,
  output logic                 ins_ready,
  input  logic [TAG_BITS-1:0]  ins_tag,
  input  logic [SET_BITS-1:0]  ins_set,
  input  logic [DATA_BITS-1:0] ins_data,
  input  logic                 ins_dirty,
  input  logic                 lkp_valid,
  input  logic [TAG_BITS-1:0]  lkp_tag,
  input  logic [SET_BITS-1:0]  lkp_set,
  output logic                 lkp_hit,
  output logic [DATA_BITS-1:0] lkp_data,
  output logic                 lkp_dirty,
  output logic                 wb_valid,
  input  logic                 wb_ready,
  output logic [TAG_BITS-1:0]  wb_tag,
  output logic [SET_BITS-1:0]  wb_set,
  output logic [DATA_BITS-1:0] wb_data,
  input  logic                 flush_req,
  output logic                 flush_done,
  output logic [OCC_W-1:0]     occupancy
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);

  typedef enum logic [1:0] {IDLE, FLUSH, DONE} state_t;

  state_t                 state_q, state_d;
  logic [NUM_ENTRIES-1:0] vld_q, vld_d;
  logic [NUM_ENTRIES-1:0] dirty_q, dirty_d;
  logic [TAG_BITS-1:0]    tag_q  [NUM_ENTRIES];
  logic [TAG_BITS-1:0]    tag_d  [NUM_ENTRIES];
  logic [SET_BITS-1:0]    set_q  [NUM_ENTRIES];
  logic [SET_BITS-1:0]    set_d  [NUM_ENTRIES];
  logic [DATA_BITS-1:0]   data_q [NUM_ENTRIES];
  logic [DATA_BITS-1:0]   data_d [NUM_ENTRIES];

  logic                   wb_vld_q, wb_vld_d;
  logic [TAG_BITS-1:0]    wb_tag_q, wb_tag_d;
  logic [SET_BITS-1:0]    wb_set_q, wb_set_d;
  logic [DATA_BITS-1:0]   wb_data_q, wb_data_d;

  logic [NUM_ENTRIES-1:0] hit_vec, dup_vec, rm_vec, keep_vec;
  logic                   full, wb_free, ins_fire;
  logic                   fl_found, fl_take, evict;
  logic [IDX_W-1:0]       fl_idx;
  int                     rank [NUM_ENTRIES];

  function automatic logic [OCC_W-1:0] pop_count(input logic [NUM_ENTRIES-1:0] v);
    logic [OCC_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) n = n + OCC_W'(v[i]);
    return n;
  endfunction

  // Tag match of stored entries against the probe and against the incoming line
  always_comb begin
    hit_vec   = '0;
    dup_vec   = '0;
    lkp_data  = '0;
    lkp_dirty = 1'b0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      hit_vec[i] = lkp_valid & vld_q[i] & (tag_q[i] == lkp_tag) & (set_q[i] == lkp_set);
      dup_vec[i] = vld_q[i] & (tag_q[i] == ins_tag) & (set_q[i] == ins_set);
      if (hit_vec[i]) begin
        lkp_data  = lkp_data | data_q[i];
        lkp_dirty = lkp_dirty | dirty_q[i];
      end
    end
  end

  assign lkp_hit    = |hit_vec;
  assign full       = &vld_q;
  assign wb_free    = ~wb_vld_q | wb_ready;
  // A hit frees a slot, so a full cache only blocks when the oldest is dirty and the buffer is stuck
  assign ins_ready  = (state_q == IDLE) &
                      (~full | lkp_hit | ~dirty_q[NUM_ENTRIES-1] | wb_free);
  assign ins_fire   = ins_valid & ins_ready;
  assign flush_done = (state_q == DONE);
  assign occupancy  = pop_count(vld_q);
  assign wb_valid   = wb_vld_q;
  assign wb_tag     = wb_vld_q ? wb_tag_q  : '0;
  assign wb_set     = wb_vld_q ? wb_set_q  : '0;
  assign wb_data    = wb_vld_q ? wb_data_q : '0;

  // Locate the oldest valid entry, which is the one a flush drains next
  always_comb begin
    fl_found = 1'b0;
    fl_idx   = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (vld_q[i]) begin
        fl_found = 1'b1;
        fl_idx   = IDX_W'(i);
      end
    end
  end

  // Decide which entries leave this cycle and the new age rank of the survivors
  always_comb begin
    fl_take = (state_q == FLUSH) & fl_found & ~hit_vec[fl_idx] &
              (~dirty_q[fl_idx] | wb_free);
    rm_vec  = hit_vec | (ins_fire ? dup_vec : '0);
    if (fl_take) rm_vec[fl_idx] = 1'b1;
    keep_vec = vld_q & ~rm_vec;
    rank[0]  = ins_fire ? 1 : 0;
    for (int i = 1; i < NUM_ENTRIES; i++) begin
      rank[i] = rank[i-1] + (keep_vec[i-1] ? 1 : 0);
    end
    // Survivor pushed past the last slot only when inserting into a full cache
    evict = ins_fire & keep_vec[NUM_ENTRIES-1] & (rank[NUM_ENTRIES-1] == NUM_ENTRIES);
  end

  // Compact survivors into age order behind the newly inserted line
  always_comb begin
    vld_d   = '0;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    set_d   = set_q;
    data_d  = data_q;
    if (ins_fire) begin
      vld_d[0]   = 1'b1;
      dirty_d[0] = ins_dirty;
      tag_d[0]   = ins_tag;
      set_d[0]   = ins_set;
      data_d[0]  = ins_data;
    end
    for (int p = 0; p < NUM_ENTRIES; p++) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (keep_vec[i] && rank[i] == p) begin
          vld_d[p]   = 1'b1;
          dirty_d[p] = dirty_q[i];
          tag_d[p]   = tag_q[i];
          set_d[p]   = set_q[i];
          data_d[p]  = data_q[i];
        end
      end
    end
  end

  // Writeback buffer: drains on handshake, reloads in the same edge if needed
  always_comb begin
    wb_vld_d  = wb_vld_q & ~wb_ready;
    wb_tag_d  = wb_tag_q;
    wb_set_d  = wb_set_q;
    wb_data_d = wb_data_q;
    if (evict && dirty_q[NUM_ENTRIES-1]) begin
      wb_vld_d  = 1'b1;
      wb_tag_d  = tag_q[NUM_ENTRIES-1];
      wb_set_d  = set_q[NUM_ENTRIES-1];
      wb_data_d = data_q[NUM_ENTRIES-1];
    end else if (fl_take && dirty_q[fl_idx]) begin
      wb_vld_d  = 1'b1;
      wb_tag_d  = tag_q[fl_idx];
      wb_set_d  = set_q[fl_idx];
      wb_data_d = data_q[fl_idx];
    end
  end

  // Flush sequencing: drain until empty and buffer idle, then pulse done
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (flush_req) state_d = FLUSH;
      FLUSH:   if (vld_q == '0 && !wb_vld_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state with asynchronous reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      vld_q    <= '0;
      wb_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      vld_q    <= vld_d;
      wb_vld_q <= wb_vld_d;
    end
  end

  // Line payloads carry no reset; their valid bits qualify them
  always_ff @(posedge clock) begin
    dirty_q   <= dirty_d;
    tag_q     <= tag_d;
    set_q     <= set_d;
    data_q    <= data_d;
    wb_tag_q  <= wb_tag_d;
    wb_set_q  <= wb_set_d;
    wb_data_q <= wb_data_d;
  end

endmodule

// File: tb/tb_vic_cache_wb.sv
// Bench for vic_cache_wb: directed scenarios with scoreboard queues for lookup
// responses and writeback transfers, checked by a negedge monitor.
module tb_vic_cache_wb;

  localparam int N  = 4;
  localparam int TB = 8;
  localparam int SB = 4;
  localparam int DB = 64;
  localparam int WL = TB + SB + DB;

  logic          clock = 1'b0;
  logic          reset;
  logic          ins_valid, ins_ready, ins_dirty;
  logic [TB-1:0] ins_tag, lkp_tag, wb_tag;
  logic [SB-1:0] ins_set, lkp_set, wb_set;
  logic [DB-1:0] ins_data, lkp_data, wb_data;
  logic          lkp_valid, lkp_hit, lkp_dirty;
  logic          wb_valid, wb_ready;
  logic          flush_req, flush_done;
  logic [2:0]    occupancy;

  int checks = 0;
  int errors = 0;
  int wb_xfers = 0;
  int xfer0, done_cnt;
  logic seen;

  logic [DB:0]   lkp_q [$];
  logic [WL-1:0] wb_q  [$];
  logic [DB:0]   le;
  logic [WL-1:0] we;

  vic_cache_wb #(.NUM_ENTRIES(N), .TAG_BITS(TB), .SET_BITS(SB), .DATA_BITS(DB)) dut (
    .clock(clock), .reset(reset),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_tag(ins_tag), .ins_set(ins_set),
    .ins_data(ins_data), .ins_dirty(ins_dirty),
    .lkp_valid(lkp_valid), .lkp_tag(lkp_tag), .lkp_set(lkp_set),
    .lkp_hit(lkp_hit), .lkp_data(lkp_data), .lkp_dirty(lkp_dirty),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_tag(wb_tag), .wb_set(wb_set),
    .wb_data(wb_data), .flush_req(flush_req), .flush_done(flush_done),
    .occupancy(occupancy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: pops expectations as the DUT produces lookups and writebacks
  always @(negedge clock) begin
    if (lkp_valid) begin
      check("lkp_pending", 128'(lkp_q.size() > 0), 128'd1);
      if (lkp_q.size() > 0) begin
        le = lkp_q.pop_front();
        check("lkp_hit", 128'(lkp_hit), 128'(le[DB]));
        check("lkp_data", 128'(lkp_data), 128'(le[DB-1:0]));
      end
    end
    if (wb_valid && wb_ready) begin
      wb_xfers++;
      check("wb_pending", 128'(wb_q.size() > 0), 128'd1);
      if (wb_q.size() > 0) begin
        we = wb_q.pop_front();
        check("wb_line", 128'({wb_tag, wb_set, wb_data}), 128'(we));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; ins_valid = 1'b0; lkp_valid = 1'b0; flush_req = 1'b0; wb_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic ins(input logic [TB-1:0] t, input logic [SB-1:0] s,
                     input logic [DB-1:0] d, input logic dty);
    ins_valid = 1'b1; ins_tag = t; ins_set = s; ins_data = d; ins_dirty = dty;
    @(negedge clock);
    check("ins_ready", 128'(ins_ready), 128'd1);
    tick();
    ins_valid = 1'b0;
  endtask

  task automatic lkp(input logic [TB-1:0] t, input logic [SB-1:0] s,
                     input logic h, input logic [DB-1:0] d);
    lkp_valid = 1'b1; lkp_tag = t; lkp_set = s;
    lkp_q.push_back({h, d});
    tick();
    lkp_valid = 1'b0;
  endtask

  task automatic expect_now(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    @(negedge clock);
    check(tag, obs, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    ins_tag = '0; ins_set = '0; ins_data = '0; ins_dirty = 1'b0;
    lkp_tag = '0; lkp_set = '0;
    do_reset();

    // Reset state
    @(negedge clock);
    check("rst_occ", 128'(occupancy), 128'd0);
    check("rst_wbv", 128'(wb_valid), 128'd0);
    check("rst_done", 128'(flush_done), 128'd0);
    check("rst_rdy", 128'(ins_ready), 128'd1);
    check("rst_wbdata", 128'(wb_data), 128'd0);
    check("rst_lkpdata", 128'(lkp_data), 128'd0);
    tick();

    // Fill, hit removes the line, second probe misses
    ins(8'd5, 4'd2, 64'hA, 1'b1);
    ins(8'd1, 4'd1, 64'hB, 1'b0);
    ins(8'd2, 4'd1, 64'hC, 1'b0);
    ins(8'd3, 4'd1, 64'hD, 1'b0);
    @(negedge clock); check("t2_occ4", 128'(occupancy), 128'd4); tick();
    lkp(8'd5, 4'd2, 1'b1, 64'hA);
    @(negedge clock); check("t2_occ3", 128'(occupancy), 128'd3); tick();
    lkp(8'd5, 4'd2, 1'b0, 64'h0);

    // Dirty overflow into a blocked writeback buffer
    do_reset();
    ins(8'd5, 4'd2, 64'hA1, 1'b1);
    ins(8'd6, 4'd2, 64'hB1, 1'b1);
    ins(8'd7, 4'd2, 64'hC1, 1'b0);
    ins(8'd8, 4'd2, 64'hD1, 1'b0);
    wb_q.push_back({8'd5, 4'd2, 64'hA1});
    ins(8'd9, 4'd2, 64'hE1, 1'b0);
    @(negedge clock);
    check("t3_wbv", 128'(wb_valid), 128'd1);
    check("t3_wbtag", 128'(wb_tag), 128'd5);
    check("t3_occ", 128'(occupancy), 128'd4);
    tick();
    ins_valid = 1'b1; ins_tag = 8'd10; ins_set = 4'd2; ins_data = 64'hF1; ins_dirty = 1'b0;
    repeat (2) begin
      @(negedge clock);
      check("t3_stall", 128'(ins_ready), 128'd0);
      check("t3_wbhold", 128'(wb_tag), 128'd5);
      tick();
    end
    wb_q.push_back({8'd6, 4'd2, 64'hB1});
    wb_ready = 1'b1;
    @(negedge clock); check("t3_rdy_free", 128'(ins_ready), 128'd1);
    tick();
    ins_valid = 1'b0; wb_ready = 1'b0;
    @(negedge clock);
    check("t3_wbv_b", 128'(wb_valid), 128'd1);
    check("t3_wbtag_b", 128'(wb_tag), 128'd6);
    check("t3_occ_b", 128'(occupancy), 128'd4);
    tick();
    wb_ready = 1'b1; tick(); wb_ready = 1'b0;
    expect_now("t3_wb_empty", 128'(wb_valid), 128'd0); tick();
    lkp(8'd7, 4'd2, 1'b1, 64'hC1);
    lkp(8'd6, 4'd2, 1'b0, 64'h0);

    // Hit and insert together: no eviction, age order new,s0,s2,s3
    do_reset();
    ins(8'h20, 4'd3, 64'h200, 1'b1);
    ins(8'h21, 4'd3, 64'h210, 1'b0);
    ins(8'h22, 4'd3, 64'h220, 1'b0);
    ins(8'h23, 4'd3, 64'h230, 1'b0);
    lkp_valid = 1'b1; lkp_tag = 8'h22; lkp_set = 4'd3;
    lkp_q.push_back({1'b1, 64'h220});
    ins_valid = 1'b1; ins_tag = 8'h30; ins_set = 4'd3; ins_data = 64'h300; ins_dirty = 1'b0;
    @(negedge clock); check("t4_rdy", 128'(ins_ready), 128'd1);
    tick();
    lkp_valid = 1'b0; ins_valid = 1'b0;
    @(negedge clock);
    check("t4_wbv", 128'(wb_valid), 128'd0);
    check("t4_occ", 128'(occupancy), 128'd4);
    tick();
    wb_q.push_back({8'h20, 4'd3, 64'h200});
    ins(8'h31, 4'd3, 64'h310, 1'b0);
    expect_now("t4_evict_wbv", 128'(wb_valid), 128'd1); tick();
    ins(8'h32, 4'd3, 64'h320, 1'b0);
    lkp(8'h21, 4'd3, 1'b0, 64'h0);
    lkp(8'h22, 4'd3, 1'b0, 64'h0);
    lkp(8'h23, 4'd3, 1'b1, 64'h230);
    lkp(8'h30, 4'd3, 1'b1, 64'h300);
    wb_ready = 1'b1; tick(); wb_ready = 1'b0;

    // Same {tag,set} inserted twice: newest copy wins
    do_reset();
    ins(8'd7, 4'd1, 64'h11, 1'b0);
    ins(8'd7, 4'd1, 64'h22, 1'b0);
    expect_now("t5_occ1", 128'(occupancy), 128'd1); tick();
    lkp(8'd7, 4'd1, 1'b1, 64'h22);
    expect_now("t5_occ0", 128'(occupancy), 128'd0); tick();

    // Flush with two dirty lines and a toggling wb_ready
    do_reset();
    ins(8'h40, 4'd5, 64'h400, 1'b1);
    ins(8'h41, 4'd5, 64'h410, 1'b0);
    ins(8'h42, 4'd5, 64'h420, 1'b1);
    wb_q.push_back({8'h40, 4'd5, 64'h400});
    wb_q.push_back({8'h42, 4'd5, 64'h420});
    xfer0 = wb_xfers;
    flush_req = 1'b1; tick(); flush_req = 1'b0;
    done_cnt = 0; seen = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      wb_ready = c[0];
      @(negedge clock);
      check("t6_rdy_low", 128'(ins_ready), 128'd0);
      if (flush_done) begin
        done_cnt++;
        seen = 1'b1;
      end
      tick();
    end
    wb_ready = 1'b0;
    check("t6_done_seen", 128'(seen), 128'd1);
    @(negedge clock);
    check("t6_rdy_idle", 128'(ins_ready), 128'd1);
    check("t6_occ", 128'(occupancy), 128'd0);
    if (flush_done) done_cnt++;
    tick();
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      if (flush_done) done_cnt++;
      tick();
    end
    check("t6_done_cnt", 128'(done_cnt), 128'd1);
    check("t6_xfers", 128'(wb_xfers - xfer0), 128'd2);

    // Reset in the middle of a flush while a writeback is pending
    do_reset();
    ins(8'h50, 4'd6, 64'h500, 1'b1);
    ins(8'h51, 4'd6, 64'h510, 1'b1);
    flush_req = 1'b1; tick(); flush_req = 1'b0;
    tick();
    @(negedge clock);
    check("t7_wbv_pre", 128'(wb_valid), 128'd1);
    check("t7_occ_pre", 128'(occupancy), 128'd1);
    #2 reset = 1'b1;
    #1;
    check("t7_wbv_rst", 128'(wb_valid), 128'd0);
    check("t7_occ_rst", 128'(occupancy), 128'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("t7_rdy", 128'(ins_ready), 128'd1);
    check("t7_done", 128'(flush_done), 128'd0);
    tick();

    check("wb_q_empty", 128'(wb_q.size()), 128'd0);
    check("lkp_q_empty", 128'(lkp_q.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
